// File: rtl/opb_register_simulink2ppc_latched.sv
// OPB readback register: user logic pushes a word, PPC reads it over OPB.
// Define OPB_S2P_STATUS_WORD_EN to add the status/overflow word at +4.
module opb_register_simulink2ppc_latched #(
  parameter logic [31:0] C_BASEADDR   = 32'h01094800,
  parameter logic [31:0] C_HIGHADDR   = 32'h010948FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic                      Sl_xferAck,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  input  logic [31:0]               user_data_in,
  input  logic                      user_valid,
  output logic                      user_ready,
  output logic                      user_read_pulse
);

  logic        ack_q;
  logic        busy_q;
  logic        pulse_q;
  logic        full_q;
  logic [31:0] hold_q;
  logic [31:0] dbus_q;
  logic [31:0] rd_val;
  logic [7:0]  off;
  logic        in_range;
  logic        hit;
  logic        off_data;
  logic        off_stat;
  logic        capture;
  logic        unused_ok;

  assign in_range = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  // busy_q holds off a second ack while the master keeps select high
  assign hit      = OPB_select && in_range && !ack_q && !busy_q;
  assign off      = OPB_ABus[C_OPB_AWIDTH-8:C_OPB_AWIDTH-1];
  assign off_data = (off == 8'h00);
  assign off_stat = (off == 8'h04);
  assign capture  = user_valid && !full_q;

  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  // Reset drops an in-flight acknowledge immediately
  assign Sl_xferAck      = ack_q && !OPB_Rst;
  assign Sl_DBus         = OPB_Rst ? '0 : dbus_q;
  assign user_read_pulse = pulse_q && !OPB_Rst;
  assign user_ready      = !full_q;

`ifdef OPB_S2P_STATUS_WORD_EN
  logic [15:0] ovf_q;
  logic        ovf_clr;

  assign ovf_clr = hit && !OPB_RNW && off_stat
                && (OPB_BE[2] || OPB_BE[3]);

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      ovf_q <= '0;
    end else if (ovf_clr) begin
      ovf_q <= '0;
    end else if (user_valid && full_q && ovf_q != 16'hFFFF) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  always_comb begin
    rd_val = '0;
    if (off_data) begin
      rd_val = hold_q;
    end else if (off_stat) begin
      rd_val = {full_q, 15'b0, ovf_q};
    end
  end
`else
  always_comb begin
    rd_val = '0;
    if (off_data) begin
      rd_val = hold_q;
    end
  end
`endif

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
      full_q  <= 1'b0;
      hold_q  <= '0;
      dbus_q  <= '0;
    end else begin
      ack_q   <= hit;
      busy_q  <= OPB_select && (busy_q || hit);
      dbus_q  <= (hit && OPB_RNW) ? rd_val : '0;
      // Only a read of a full register consumes the word
      pulse_q <= hit && OPB_RNW && off_data && full_q;
      if (capture) begin
        hold_q <= user_data_in;
        full_q <= 1'b1;
      end else if (pulse_q) begin
        full_q <= 1'b0;
      end
    end
  end

  assign unused_ok = &{1'b0, OPB_seqAddr, OPB_DBus, OPB_BE,
                       (C_FAMILY == "")};

endmodule

// File: tb/tb_opb_register_simulink2ppc_latched.sv
// Randomized bench for opb_register_simulink2ppc_latched.
// Builds with or without OPB_S2P_STATUS_WORD_EN.
module tb_opb_register_simulink2ppc_latched;

  localparam logic [31:0] BASE = 32'h01094800;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] sl_dbus;
  logic        sl_erracck;
  logic        sl_retry;
  logic        sl_toutsup;
  logic        ack;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] wbus;
  logic        rnw;
  logic        sel;
  logic        seqaddr;
  logic [31:0] udata;
  logic        uvalid;
  logic        uready;
  logic        upulse;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hold;
  logic        m_full;
  int          m_ovf;

  always #5 clk = ~clk;

  opb_register_simulink2ppc_latched dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .Sl_DBus(sl_dbus),
    .Sl_errAck(sl_erracck), .Sl_retry(sl_retry),
    .Sl_toutSup(sl_toutsup), .Sl_xferAck(ack),
    .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(wbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqaddr),
    .user_data_in(udata), .user_valid(uvalid),
    .user_ready(uready), .user_read_pulse(upulse)
  );

  function automatic void m_push(input logic [31:0] v);
    if (!m_full) begin
      m_hold = v;
      m_full = 1'b1;
    end else if (m_ovf < 65535) begin
      m_ovf++;
    end
  endfunction

  function automatic logic [31:0] m_status();
`ifdef OPB_S2P_STATUS_WORD_EN
    logic [15:0] c;
    c = 16'(m_ovf);
    return {m_full, 15'b0, c};
`else
    return 32'h0;
`endif
  endfunction

  task automatic push(input logic [31:0] v, output logic rdy);
    @(posedge clk); #1;
    uvalid = 1'b1;
    udata  = v;
    @(negedge clk);
    rdy = uready;
    @(posedge clk); #1;
    uvalid = 1'b0;
  endtask

  task automatic opb_cycle(input logic r, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] b,
                           output logic a0, output logic a1,
                           output logic [31:0] d1, output logic p1,
                           output logic a2);
    @(posedge clk); #1;
    sel = 1'b1; rnw = r; abus = a; wbus = wd; be = b;
    @(negedge clk);
    a0 = ack;
    @(posedge clk); #1;
    sel = 1'b0; abus = '0;
    @(negedge clk);
    a1 = ack; d1 = sl_dbus; p1 = upulse;
    @(posedge clk); #1;
    @(negedge clk);
    a2 = ack;
  endtask

  task automatic test_reset();
    logic a0, a1, p1, a2;
    logic [31:0] d1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_hold = '0; m_full = 1'b0; m_ovf = 0;
    @(negedge clk);
    total++;
    if (uready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", uready); end
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b want=0", ack); end
    total++;
    if (upulse !== 1'b0) begin bad++; $display("FAIL rst_pulse got=%b want=0", upulse); end
    opb_cycle(1'b1, BASE, 32'h0, 4'hF, a0, a1, d1, p1, a2);
    total++;
    if ({a0, a1, a2} !== 3'b010) begin bad++; $display("FAIL rst_read_ack got=%b want=010", {a0, a1, a2}); end
    total++;
    if (d1 !== 32'h0) begin bad++; $display("FAIL rst_read_data got=%h want=0", d1); end
  endtask

  task automatic test_capture_read();
    logic a0, a1, p1, a2, rdy;
    logic [31:0] d1;
    push(32'hDEADBEEF, rdy);
    m_push(32'hDEADBEEF);
    total++;
    if (rdy !== 1'b1) begin bad++; $display("FAIL cap_ready got=%b want=1", rdy); end
    opb_cycle(1'b1, BASE, 32'h0, 4'hF, a0, a1, d1, p1, a2);
    total++;
    if ({a0, a1, a2} !== 3'b010) begin bad++; $display("FAIL cap_ack got=%b want=010", {a0, a1, a2}); end
    total++;
    if (d1 !== 32'hDEADBEEF) begin bad++; $display("FAIL cap_data got=%h want=deadbeef", d1); end
    total++;
    if (p1 !== 1'b1) begin bad++; $display("FAIL cap_pulse got=%b want=1", p1); end
    m_full = 1'b0;
    total++;
    if (uready !== 1'b1) begin bad++; $display("FAIL cap_ready_after got=%b want=1", uready); end
  endtask

  task automatic test_overflow();
    logic a0, a1, p1, a2, rdy;
    logic [31:0] d1;
    for (int i = 1; i <= 3; i++) begin
      push(32'(i), rdy);
      total++;
      if (rdy !== !m_full) begin bad++; $display("FAIL ovf_ready%0d got=%b want=%b", i, rdy, !m_full); end
      m_push(32'(i));
    end
    opb_cycle(1'b1, BASE + 32'd4, 32'h0, 4'hF, a0, a1, d1, p1, a2);
    total++;
    if (d1 !== m_status()) begin bad++; $display("FAIL ovf_stat_pre got=%h want=%h", d1, m_status()); end
    opb_cycle(1'b1, BASE, 32'h0, 4'hF, a0, a1, d1, p1, a2);
    total++;
    if (d1 !== 32'h1) begin bad++; $display("FAIL ovf_data got=%h want=1", d1); end
    m_full = 1'b0;
    opb_cycle(1'b1, BASE + 32'd4, 32'h0, 4'hF, a0, a1, d1, p1, a2);
    total++;
    if (d1 !== m_status()) begin bad++; $display("FAIL ovf_stat_post got=%h want=%h", d1, m_status()); end
  endtask

  task automatic test_held_select();
    logic rdy;
    logic [31:0] v, got;
    int acks, pulses;
    v = $urandom;
    push(v, rdy);
    m_push(v);
    acks = 0; pulses = 0; got = '0;
    @(posedge clk); #1;
    sel = 1'b1; rnw = 1'b1; abus = BASE;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) begin acks++; got = sl_dbus; end
      if (upulse) pulses++;
      @(posedge clk); #1;
      if (i == 3) sel = 1'b0;
    end
    m_full = 1'b0;
    total++;
    if (acks !== 1) begin bad++; $display("FAIL held_acks got=%0d want=1", acks); end
    total++;
    if (pulses !== 1) begin bad++; $display("FAIL held_pulses got=%0d want=1", pulses); end
    total++;
    if (got !== m_hold) begin bad++; $display("FAIL held_data got=%h want=%h", got, m_hold); end
  endtask

  task automatic test_address_range();
    logic a0, a1, p1, a2;
    logic [31:0] d1;
    opb_cycle(1'b0, BASE, 32'hFFFFFFFF, 4'hF, a0, a1, d1, p1, a2);
    total++;
    if ({a0, a1, a2} !== 3'b010) begin bad++; $display("FAIL wr0_ack got=%b want=010", {a0, a1, a2}); end
    opb_cycle(1'b1, BASE, 32'h0, 4'hF, a0, a1, d1, p1, a2);
    total++;
    if (d1 !== m_hold) begin bad++; $display("FAIL wr0_hold got=%h want=%h", d1, m_hold); end
    total++;
    if (p1 !== 1'b0) begin bad++; $display("FAIL stale_pulse got=%b want=0", p1); end
    opb_cycle(1'b1, 32'h01094900, 32'h0, 4'hF, a0, a1, d1, p1, a2);
    total++;
    if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL oor_ack got=%b want=000", {a0, a1, a2}); end
    opb_cycle(1'b1, BASE + 32'd4, 32'h0, 4'hF, a0, a1, d1, p1, a2);
    total++;
    if (d1 !== m_status()) begin bad++; $display("FAIL off1_read got=%h want=%h", d1, m_status()); end
    opb_cycle(1'b1, BASE + 32'h10, 32'h0, 4'hF, a0, a1, d1, p1, a2);
    total++;
    if ({a1, d1} !== {1'b1, 32'h0}) begin bad++; $display("FAIL unmapped got=%b/%h want=1/0", a1, d1); end
  endtask

  task automatic test_status_clear();
    logic a0, a1, p1, a2, rdy;
    logic [31:0] d1;
    for (int i = 0; i < 3; i++) begin
      push($urandom, rdy);
      m_push(32'h0);
      if (i == 0 && rdy) m_hold = udata;
    end
    opb_cycle(1'b0, BASE + 32'd4, 32'h0, 4'b1000, a0, a1, d1, p1, a2);
    opb_cycle(1'b1, BASE + 32'd4, 32'h0, 4'hF, a0, a1, d1, p1, a2);
    total++;
    if (d1 !== m_status()) begin bad++; $display("FAIL clr_be0 got=%h want=%h", d1, m_status()); end
    opb_cycle(1'b0, BASE + 32'd4, 32'h0, 4'b0001, a0, a1, d1, p1, a2);
`ifdef OPB_S2P_STATUS_WORD_EN
    m_ovf = 0;
`endif
    opb_cycle(1'b1, BASE + 32'd4, 32'h0, 4'hF, a0, a1, d1, p1, a2);
    total++;
    if (d1 !== m_status()) begin bad++; $display("FAIL clr_be3 got=%h want=%h", d1, m_status()); end
  endtask

  task automatic test_simultaneous();
    logic rdy;
    logic [31:0] v, d1;
    logic a0, a1, p1, a2;
    if (!m_full) begin
      v = $urandom;
      push(v, rdy);
      m_push(v);
    end
    v = $urandom;
    @(posedge clk); #1;
    sel = 1'b1; rnw = 1'b1; abus = BASE;
    @(posedge clk); #1;
    sel = 1'b0; uvalid = 1'b1; udata = v;
    @(negedge clk);
    total++;
    if ({ack, upulse, uready} !== 3'b110) begin bad++; $display("FAIL sim_flags got=%b want=110", {ack, upulse, uready}); end
    total++;
    if (sl_dbus !== m_hold) begin bad++; $display("FAIL sim_data got=%h want=%h", sl_dbus, m_hold); end
    @(posedge clk); #1;
    uvalid = 1'b0;
    m_push(v);
    m_full = 1'b0;
    @(negedge clk);
    total++;
    if (uready !== 1'b1) begin bad++; $display("FAIL sim_ready got=%b want=1", uready); end
    opb_cycle(1'b1, BASE, 32'h0, 4'hF, a0, a1, d1, p1, a2);
    total++;
    if ({d1, p1} !== {m_hold, 1'b0}) begin bad++; $display("FAIL sim_stale got=%h/%b want=%h/0", d1, p1, m_hold); end
    opb_cycle(1'b1, BASE + 32'd4, 32'h0, 4'hF, a0, a1, d1, p1, a2);
    total++;
    if (d1 !== m_status()) begin bad++; $display("FAIL sim_stat got=%h want=%h", d1, m_status()); end
  endtask

  task automatic test_random();
    logic a0, a1, p1, a2, rdy;
    logic [31:0] d1, v, want;
    for (int n = 0; n < 150; n++) begin
      v = $urandom;
      case ($urandom_range(0, 3))
        0: begin
          push(v, rdy);
          total++;
          if (rdy !== !m_full) begin bad++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, rdy, !m_full); end
          m_push(v);
        end
        1: begin
          opb_cycle(1'b1, BASE, 32'h0, 4'hF, a0, a1, d1, p1, a2);
          total++;
          if ({a1, d1, p1} !== {1'b1, m_hold, m_full}) begin
            bad++;
            $display("FAIL rnd_read n=%0d got=%b/%h/%b want=1/%h/%b", n, a1, d1, p1, m_hold, m_full);
          end
          m_full = 1'b0;
        end
        2: begin
          want = m_status();
          opb_cycle(1'b1, BASE + 32'd4, 32'h0, 4'hF, a0, a1, d1, p1, a2);
          total++;
          if (d1 !== want) begin bad++; $display("FAIL rnd_stat n=%0d got=%h want=%h", n, d1, want); end
        end
        default: begin
          opb_cycle(1'b0, BASE, v, 4'hF, a0, a1, d1, p1, a2);
          total++;
          if ({a1, d1} !== {1'b1, 32'h0}) begin bad++; $display("FAIL rnd_write n=%0d got=%b/%h want=1/0", n, a1, d1); end
        end
      endcase
    end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, p1, a2, rdy;
    logic [31:0] d1;
    push(32'hCAFEF00D, rdy);
    @(posedge clk); #1;
    sel = 1'b1; rnw = 1'b1; abus = BASE;
    @(posedge clk); #1;
    sel = 1'b0; rst = 1'b1;
    @(negedge clk);
    total++;
    if ({ack, upulse} !== 2'b00) begin bad++; $display("FAIL mid_ack got=%b want=00", {ack, upulse}); end
    @(posedge clk); #1;
    rst = 1'b0;
    m_hold = '0; m_full = 1'b0; m_ovf = 0;
    @(negedge clk);
    total++;
    if (uready !== 1'b1) begin bad++; $display("FAIL mid_full got=%b want=1", uready); end
    opb_cycle(1'b1, BASE, 32'h0, 4'hF, a0, a1, d1, p1, a2);
    total++;
    if ({d1, p1} !== {m_hold, 1'b0}) begin bad++; $display("FAIL mid_lost got=%h/%b want=0/0", d1, p1); end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; rnw = 1'b1; abus = '0; be = '0;
    wbus = '0; seqaddr = 1'b0; udata = '0; uvalid = 1'b0;
    m_hold = '0; m_full = 1'b0; m_ovf = 0;
    test_reset();
    test_capture_read();
    test_overflow();
    test_held_select();
    test_address_range();
    test_status_clear();
    test_simultaneous();
    test_random();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
